// File: rtl/sel_split_n_d.sv
// sel_split_n_d: steers one drive/free token to NUM_OUT consumers,
// select or broadcast, with sticky error flags and a WAIT watchdog.
module sel_split_n_d #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 4,
  parameter int MODE       = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_drive,
  input  logic [NUM_OUT-1:0]            i_valid,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic                          o_free,
  output logic                          o_ready,
  output logic [NUM_OUT-1:0]            o_driveNext,
  input  logic [NUM_OUT-1:0]            i_freeNext,
  output logic [NUM_OUT*DATA_WIDTH-1:0] o_data,
  output logic                          o_err_sel,
  output logic                          o_err_ovr,
  output logic                          o_timeout,
  input  logic                          i_clr_err
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] dataQ;
  logic [NUM_OUT-1:0]    pend;
  logic [NUM_OUT-1:0]    pendNext;
  logic [NUM_OUT-1:0]    lowBit;
  logic [NUM_OUT-1:0]    tgt;
  logic [15:0]           wdog;
  logic [16:0]           wdogInc;
  logic                  multiHot;
  logic                  selEvt;
  logic                  ovrEvt;
  logic                  toEvt;

  assign lowBit   = i_valid & (~i_valid + NUM_OUT'(1));
  assign tgt      = (MODE == 0) ? lowBit : i_valid;
  assign multiHot = (i_valid & (i_valid - NUM_OUT'(1))) != '0;
  assign pendNext = pend & ~i_freeNext;
  assign wdogInc  = {1'b0, wdog} + 17'd1;

  assign selEvt = (state == IDLE) && i_drive &&
                  ((tgt == '0) || ((MODE == 0) && multiHot));
  assign ovrEvt = i_drive && (state != IDLE);
  // Fires on the WAIT cycle that completes TIMEOUT cycles still pending
  assign toEvt  = (TIMEOUT != 0) && (state == WAIT) &&
                  (pendNext != '0) && (wdogInc >= 17'(TIMEOUT));

  assign o_data = {NUM_OUT{dataQ}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dataQ       <= '0;
      pend        <= '0;
      wdog        <= '0;
      o_free      <= 1'b0;
      o_ready     <= 1'b1;
      o_driveNext <= '0;
      o_err_sel   <= 1'b0;
      o_err_ovr   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_free      <= 1'b0;
      o_driveNext <= '0;
      o_err_sel   <= selEvt | (o_err_sel & ~i_clr_err);
      o_err_ovr   <= ovrEvt | (o_err_ovr & ~i_clr_err);
      o_timeout   <= toEvt | (o_timeout & ~i_clr_err);
      unique case (state)
        IDLE: begin
          if (i_drive) begin
            dataQ   <= i_data;
            o_ready <= 1'b0;
            if (tgt != '0) begin
              state       <= SEND;
              o_driveNext <= tgt;
              pend        <= tgt;
            end else begin
              state  <= DONE;
              o_free <= 1'b1;
            end
          end
        end
        SEND: begin
          pend <= pendNext;
          wdog <= '0;
          if (pendNext == '0) begin
            state  <= DONE;
            o_free <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          pend <= pendNext;
          if (pendNext == '0) begin
            state  <= DONE;
            o_free <= 1'b1;
            wdog   <= '0;
          end else if (wdog != '1) begin
            wdog <= wdog + 16'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sel_split_n_d.sv
// Scoreboard bench for sel_split_n_d: one select-mode instance with a
// watchdog and one broadcast-mode instance, driven with random tokens.
module tb_sel_split_n_d;

  logic         clk = 1'b0;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  logic         rst[2];
  logic         drive[2];
  logic [3:0]   valid[2];
  logic [31:0]  data[2];
  logic [3:0]   freeN[2];
  logic         clr[2];
  logic         oFree[2];
  logic         oReady[2];
  logic [3:0]   oDn[2];
  logic [127:0] oData[2];
  logic         oSel[2];
  logic         oOvr[2];
  logic         oTo[2];

  logic         expSel[2];
  logic         expOvr[2];
  logic         expTo[2];

  typedef struct {int inst; logic [3:0] m; logic [31:0] d;} dn_t;
  typedef struct {int inst; int at; logic [31:0] d;} fr_t;
  dn_t dnQ[$];
  fr_t frQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sel_split_n_d #(.DATA_WIDTH(32), .NUM_OUT(4), .MODE(0), .TIMEOUT(8)) u0 (
    .clk(clk), .rst(rst[0]), .i_drive(drive[0]), .i_valid(valid[0]),
    .i_data(data[0]), .o_free(oFree[0]), .o_ready(oReady[0]),
    .o_driveNext(oDn[0]), .i_freeNext(freeN[0]), .o_data(oData[0]),
    .o_err_sel(oSel[0]), .o_err_ovr(oOvr[0]), .o_timeout(oTo[0]),
    .i_clr_err(clr[0])
  );

  sel_split_n_d #(.DATA_WIDTH(32), .NUM_OUT(4), .MODE(1), .TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst[1]), .i_drive(drive[1]), .i_valid(valid[1]),
    .i_data(data[1]), .o_free(oFree[1]), .o_ready(oReady[1]),
    .o_driveNext(oDn[1]), .i_freeNext(freeN[1]), .o_data(oData[1]),
    .o_err_sel(oSel[1]), .o_err_ovr(oOvr[1]), .o_timeout(oTo[1]),
    .i_clr_err(clr[1])
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT emits driveNext or free
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (oDn[i] != 4'd0) begin
        if (dnQ.size() == 0) begin
          chk("driveNext_unexpected", {124'd0, oDn[i]}, 128'd0);
        end else begin
          dn_t e;
          e = dnQ.pop_front();
          chk("driveNext_inst", i, e.inst);
          chk("driveNext_mask", oDn[i], e.m);
          chk("driveNext_data", oData[i], {4{e.d}});
        end
      end
      if (oFree[i]) begin
        if (frQ.size() == 0) begin
          chk("free_unexpected", 1, 0);
        end else begin
          fr_t f;
          f = frQ.pop_front();
          chk("free_inst", i, f.inst);
          chk("free_cycle", cyc, f.at);
          chk("free_data", oData[i], {4{f.d}});
        end
      end
    end
  end

  task automatic chkFlags(int i);
    chk("err_sel", oSel[i], expSel[i]);
    chk("err_ovr", oOvr[i], expOvr[i]);
    chk("timeout", oTo[i], expTo[i]);
  endtask

  task automatic clrFlags(int i);
    @(negedge clk);
    clr[i] = 1'b1;
    @(negedge clk);
    clr[i] = 1'b0;
    expSel[i] = 1'b0;
    expOvr[i] = 1'b0;
    expTo[i] = 1'b0;
    chkFlags(i);
  endtask

  // One token: model picks targets and per-channel free delays
  task automatic runTxn(int i, logic [3:0] v, logic [31:0] d, bit ovr);
    int t, mx, ovrAt;
    int dl[4];
    logic [3:0] tg, fn;
    @(negedge clk);
    t = cyc;
    tg = 4'd0;
    if (i == 0) begin
      for (int k = 0; k < 4; k++)
        if (v[k] && tg == 4'd0) tg[k] = 1'b1;
    end else begin
      tg = v;
    end
    if (tg == 4'd0 || (i == 0 && $countones(v) > 1)) expSel[i] = 1'b1;
    mx = 0;
    for (int k = 0; k < 4; k++) begin
      dl[k] = tg[k] ? int'($urandom_range(1, 6)) : 0;
      if (dl[k] > mx) mx = dl[k];
    end
    drive[i] = 1'b1;
    valid[i] = v;
    data[i] = d;
    if (tg != 4'd0) dnQ.push_back('{i, tg, d});
    frQ.push_back('{i, t + mx + 1, d});
    ovrAt = (ovr && mx > 0) ? int'($urandom_range(1, mx)) : 0;
    for (int c = 1; c <= mx; c++) begin
      @(negedge clk);
      drive[i] = 1'b0;
      data[i] = $urandom;
      fn = 4'd0;
      for (int k = 0; k < 4; k++) begin
        if (!tg[k] && $urandom_range(0, 3) == 0) fn[k] = 1'b1;
        if (dl[k] == c) fn[k] = 1'b1;
      end
      freeN[i] = fn;
      if (c == ovrAt) begin
        drive[i] = 1'b1;
        valid[i] = 4'($urandom);
        expOvr[i] = 1'b1;
      end
    end
    @(negedge clk);
    drive[i] = 1'b0;
    freeN[i] = 4'd0;
    chk("ready_busy", oReady[i], 0);
    @(negedge clk);
    chk("ready_idle", oReady[i], 1);
    chkFlags(i);
  endtask

  // Long WAIT with no frees, then a late free
  task automatic timeoutTest(int i);
    int t;
    @(negedge clk);
    t = cyc;
    drive[i] = 1'b1;
    valid[i] = 4'b0001;
    data[i] = 32'h7000_0000 + i;
    dnQ.push_back('{i, 4'b0001, 32'h7000_0000 + i});
    frQ.push_back('{i, t + 13, 32'h7000_0000 + i});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      drive[i] = 1'b0;
      freeN[i] = (c == 12) ? 4'b0001 : 4'b0000;
      if (c == 9) chk("timeout_early", oTo[i], 0);
      if (c == 10) begin
        chk("timeout_set", oTo[i], (i == 0) ? 1 : 0);
        chk("timeout_ready", oReady[i], 0);
      end
    end
    if (i == 0) expTo[i] = 1'b1;
    @(negedge clk);
    freeN[i] = 4'd0;
    @(negedge clk);
    chk("timeout_idle", oReady[i], 1);
    chkFlags(i);
  endtask

  task automatic resetTest(int i);
    @(negedge clk);
    drive[i] = 1'b1;
    valid[i] = 4'b0011;
    data[i] = 32'h1234_5678;
    dnQ.push_back('{i, (i == 0) ? 4'b0001 : 4'b0011, 32'h1234_5678});
    @(negedge clk);
    drive[i] = 1'b0;
    @(negedge clk);
    rst[i] = 1'b1;
    @(negedge clk);
    rst[i] = 1'b0;
    expSel[i] = 1'b0;
    expOvr[i] = 1'b0;
    expTo[i] = 1'b0;
    chk("rst_ready", oReady[i], 1);
    chk("rst_dn", oDn[i], 0);
    chk("rst_free", oFree[i], 0);
    chk("rst_data", oData[i], 0);
    chkFlags(i);
    @(negedge clk);
    freeN[i] = 4'b0011;
    @(negedge clk);
    freeN[i] = 4'd0;
    chk("stale_free1", oFree[i], 0);
    @(negedge clk);
    chk("stale_free2", oFree[i], 0);
    chk("stale_ready", oReady[i], 1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      drive[i] = 1'b0;
      valid[i] = 4'd0;
      data[i] = 32'd0;
      freeN[i] = 4'd0;
      clr[i] = 1'b0;
      expSel[i] = 1'b0;
      expOvr[i] = 1'b0;
      expTo[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", oReady[i], 1);
      chk("reset_dn", oDn[i], 0);
      chk("reset_free", oFree[i], 0);
      chk("reset_data", oData[i], 0);
      chkFlags(i);
    end

    runTxn(0, 4'b0100, 32'hA5A5_0001, 0);
    runTxn(0, 4'b0110, 32'hA5A5_0002, 0);
    clrFlags(0);
    runTxn(0, 4'b0000, 32'hA5A5_0003, 0);
    clrFlags(0);
    runTxn(1, 4'b1011, 32'hA5A5_0004, 0);
    runTxn(1, 4'b1111, 32'hA5A5_0005, 1);
    clrFlags(1);

    for (int n = 0; n < 60; n++) begin
      int i;
      i = n % 2;
      runTxn(i, 4'($urandom), $urandom, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) clrFlags(i);
    end

    for (int i = 0; i < 2; i++) begin
      clrFlags(i);
      timeoutTest(i);
      clrFlags(i);
      resetTest(i);
    end

    // Error event coinciding with a clear keeps the flag set
    @(negedge clk);
    drive[0] = 1'b1;
    valid[0] = 4'd0;
    data[0] = 32'hC1C1_C1C1;
    clr[0] = 1'b1;
    expSel[0] = 1'b1;
    frQ.push_back('{0, cyc + 1, 32'hC1C1_C1C1});
    @(negedge clk);
    drive[0] = 1'b0;
    clr[0] = 1'b0;
    @(negedge clk);
    chk("clr_vs_evt_ready", oReady[0], 1);
    chkFlags(0);

    repeat (3) @(negedge clk);
    chk("dnQ_empty", dnQ.size(), 0);
    chk("frQ_empty", frQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
